// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 multiplexer with a manual select mode and an automatic
// round-robin scan mode that dwells DWELL cycles on each channel.
module mux_nto1_scan #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          mode,
  input  logic [SEL_W-1:0]              sel,
  input  logic [(2**SEL_W)*WIDTH-1:0]   din,
  output logic [WIDTH-1:0]              F,
  output logic [SEL_W-1:0]              chan,
  output logic                          wrap
);

  localparam int unsigned CH    = 2 ** SEL_W;
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] PtrLast = SEL_W'(CH - 1);

  logic [WIDTH-1:0] f_q, f_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             wrap_q, wrap_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] src;

  // Next-state: manual mode reloads the scan pointer so a later scan starts at sel with a full dwell.
  always_comb begin
    f_d    = f_q;
    chan_d = chan_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    src    = mode ? ptr_q : sel;
    if (en) begin
      f_d    = din[src*WIDTH +: WIDTH];
      chan_d = src;
      if (!mode) begin
        ptr_d = sel;
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        cnt_d  = '0;
        ptr_d  = ptr_q + SEL_W'(1);
        wrap_d = (ptr_q == PtrLast);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= '0;
      chan_q <= '0;
      wrap_q <= 1'b0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      f_q    <= f_d;
      chan_q <= chan_d;
      wrap_q <= wrap_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign F    = f_q;
  assign chan = chan_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Randomised scoreboard bench for mux_nto1_scan with a position-based scan model.
module tb_mux_nto1_scan;

  localparam int WIDTH = 8;
  localparam int SEL_W = 2;
  localparam int DWELL = 3;
  localparam int CH    = 4;
  localparam int STEPS = CH * DWELL;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0;
  logic                  mode = 1'b0;
  logic [SEL_W-1:0]      sel = '0;
  logic [CH*WIDTH-1:0]   din = '0;
  logic [WIDTH-1:0]      F;
  logic [SEL_W-1:0]      chan;
  logic                  wrap;

  mux_nto1_scan #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .sel (sel),
    .din (din),
    .F   (F),
    .chan(chan),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic [SEL_W-1:0] c;
    logic             w;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: scan position counted in cycles over one full sweep (0 .. CH*DWELL-1).
  int               pos = 0;
  logic [WIDTH-1:0] m_f = '0;
  int               m_chan = 0;
  logic             m_wrap = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] chan_of(input logic [CH*WIDTH-1:0] d, input int k);
    logic [CH*WIDTH-1:0] t;
    t = d >> (k * WIDTH);
    return t[WIDTH-1:0];
  endfunction

  function automatic void model_reset();
    pos = 0; m_f = '0; m_chan = 0; m_wrap = 1'b0;
  endfunction

  function automatic void model_step(input logic e, input logic m, input int s,
                                     input logic [CH*WIDTH-1:0] d);
    int c;
    m_wrap = 1'b0;
    if (!e) return;
    if (!m) begin
      m_f = chan_of(d, s); m_chan = s; pos = s * DWELL;
    end else begin
      c = pos / DWELL;
      m_f = chan_of(d, c); m_chan = c;
      pos = (pos + 1) % STEPS;
      m_wrap = (pos == 0);
    end
  endfunction

  // Apply inputs now (between edges) and queue the response expected at the next edge.
  task automatic step_now(input logic e, input logic m, input int s,
                          input logic [CH*WIDTH-1:0] d);
    exp_t x;
    en = e; mode = m; sel = SEL_W'(s); din = d;
    model_step(e, m, s, d);
    x.f = m_f; x.c = SEL_W'(m_chan); x.w = m_wrap;
    q.push_back(x);
  endtask

  task automatic cycle(input logic e, input logic m, input int s,
                       input logic [CH*WIDTH-1:0] d);
    @(negedge clk);
    step_now(e, m, s, d);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic async_reset(input logic [CH*WIDTH-1:0] d);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("areset_F", 32'(F), 32'd0);
    check("areset_chan", 32'(chan), 32'd0);
    check("areset_wrap", 32'(wrap), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    step_now(1'b1, 1'b1, 0, d);
  endtask

  // Monitor: compare every registered output against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (!rst && q.size() > 0) begin : pop_blk
      exp_t x;
      x = q.pop_front();
      check("F", 32'(F), 32'(x.f));
      check("chan", 32'(chan), 32'(x.c));
      check("wrap", 32'(wrap), 32'(x.w));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH*WIDTH-1:0] ramp;
    int                  guard;
    for (int k = 0; k < CH; k++) ramp[k*WIDTH +: WIDTH] = WIDTH'(8'hA0 + k);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_F", 32'(F), 32'd0);
    check("reset_chan", 32'(chan), 32'd0);
    check("reset_wrap", 32'(wrap), 32'd0);
    rst = 1'b0;
    model_reset();

    // Scan from reset: two full sweeps plus one, covering the wrap pulse
    step_now(1'b1, 1'b1, 0, ramp);
    repeat (2 * STEPS) cycle(1'b1, 1'b1, 0, ramp);

    // en gating mid-dwell
    cycle(1'b1, 1'b1, 0, ramp);
    repeat (5) cycle(1'b0, 1'b1, $urandom_range(0, CH - 1), $urandom());
    repeat (STEPS) cycle(1'b1, 1'b1, 0, ramp);

    // Manual truth table: one-hot then all-but-one bit patterns on the selected channel
    for (int s = 0; s < CH; s++) begin
      logic [CH*WIDTH-1:0] hot;
      hot = '0;
      hot[s*WIDTH] = 1'b1;
      cycle(1'b1, 1'b0, s, hot);
      cycle(1'b1, 1'b0, s, ~hot);
      cycle(1'b1, 1'b0, s, ramp);
    end

    // Mode handoff: manual sel=2, then scan, then manual sel=1
    repeat (2) cycle(1'b1, 1'b0, 2, ramp);
    repeat (6) cycle(1'b1, 1'b1, 0, ramp);
    cycle(1'b1, 1'b0, 1, ramp);

    // Async reset while channel 2 is on the output
    guard = 0;
    cycle(1'b1, 1'b1, 0, ramp);
    while (m_chan != 2 && guard < 4 * STEPS) begin
      cycle(1'b1, 1'b1, 0, ramp);
      guard++;
    end
    @(posedge clk);
    #2;
    check("pre_reset_chan", 32'(chan), 32'd2);
    async_reset(ramp);
    repeat (STEPS + 2) cycle(1'b1, 1'b1, 0, ramp);

    // Randomised traffic, mostly scanning, with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset($urandom());
      end else begin
        cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
              $urandom_range(0, CH - 1), $urandom());
      end
    end

    // Drain and confirm every expectation was consumed
    repeat (3) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
